// File: rtl/fmul_issue_queue.sv
// fmul_issue_queue: buffers FP multiply requests and feeds the pipelined multiplier one op at a time.
// Latency: a request accepted at edge E0 raises mul_en after E1, and its result is presented after E3.
// Backpressure: in_ready drops when the FIFO is full. No new op issues while the result slot is full.
//
// Ports:
//   clk, reset                  - system clock; asynchronous active-high reset
//   in_valid/in_ready           - request handshake carrying in_x1, in_x2, in_tag
//   mul_x1/mul_x2/mul_en        - registered operands and a one-cycle launch strobe to the multiplier
//   mul_idle/mul_y/mul_valid    - multiplier idle flag, product, and one-cycle product strobe
//   out_valid/out_ready         - result handshake carrying out_y, out_tag
//   count                       - request FIFO occupancy
module fmul_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_x1,
  input  logic [31:0]            in_x2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [31:0]            mul_x1,
  output logic [31:0]            mul_x2,
  output logic                   mul_en,
  input  logic                   mul_idle,
  input  logic [31:0]            mul_y,
  input  logic                   mul_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_y,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           r_state;
  logic [31:0]      r_x1_mem  [DEPTH];
  logic [31:0]      r_x2_mem  [DEPTH];
  logic [TAG_W-1:0] r_tag_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [TAG_W-1:0] r_tag;

  logic w_push;
  logic w_issue;

  // in_ready deliberately ignores a same-cycle pop, keeping it a pure function of state.
  assign in_ready = (r_count != FULL);
  assign w_push   = in_valid && in_ready;
  // Issue needs an empty result slot, so a captured product can never be overwritten.
  // Because out_valid is registered, issue follows a drain by one cycle.
  assign w_issue  = (r_state == S_IDLE) && (r_count != '0) && mul_idle && !out_valid;
  assign count    = r_count;

  // FIFO payload storage. Contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_x1_mem[r_wr_ptr]  <= in_x1;
      r_x2_mem[r_wr_ptr]  <= in_x2;
      r_tag_mem[r_wr_ptr] <= in_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer with registered multiplier and result-slot outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      mul_en    <= 1'b0;
      mul_x1    <= '0;
      mul_x2    <= '0;
      r_tag     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            mul_x1  <= r_x1_mem[r_rd_ptr];
            mul_x2  <= r_x2_mem[r_rd_ptr];
            r_tag   <= r_tag_mem[r_rd_ptr];
            mul_en  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The multiplier samples mul_en at this edge.
          mul_en  <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // out_valid is known to be 0 here, so capture cannot collide with a drain.
          if (mul_valid) begin
            out_y     <= mul_y;
            out_tag   <= r_tag;
            out_valid <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          mul_en  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_issue_queue.sv
// tb_fmul_issue_queue: drives the fmul issue queue against a behavioural multiplier and scoreboard.
// Latency: the multiplier model answers mul_lat cycles after it samples mul_en.
// Backpressure: out_ready and a foreign-busy flag are driven per test, either fixed or random.
module tb_fmul_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_x1;
  logic [31:0]            in_x2;
  logic [TAG_W-1:0]       in_tag;
  logic [31:0]            mul_x1;
  logic [31:0]            mul_x2;
  logic                   mul_en;
  wire                    mul_idle;
  logic [31:0]            mul_y;
  logic                   mul_valid;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_y;
  logic [TAG_W-1:0]       out_tag;
  logic [$clog2(DEPTH):0] count;

  logic model_busy;
  logic foreign_busy;
  int   mul_lat;
  int   spur_req;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
  } op_t;

  logic [31:0] vals [8] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                            32'hBF800000, 32'hC0000000, 32'h3F000000, 32'h3FC00000};

  assign mul_idle = !(model_busy || foreign_busy);

  fmul_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_en(mul_en), .mul_idle(mul_idle),
    .mul_y(mul_y), .mul_valid(mul_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Exact single-precision product for the operand table (zero flushes to +0).
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_val();
    logic [2:0] ix;
    ix = 3'($urandom);
    return vals[ix];
  endfunction

  // Multiplier model: samples mul_en, then pulses mul_valid for one cycle mul_lat cycles later.
  // After the pulse it drives a corrupted product so that a late capture is visible.
  initial begin
    int          sd;
    logic [31:0] p;
    sd = 0;
    mul_valid = 1'b0;
    mul_y = 32'h0;
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mul_en) begin
        p = fp_mul(mul_x1, mul_x2);
        model_busy = 1'b1;
        repeat (mul_lat) @(posedge clk);
        #1 mul_valid = 1'b1;
        mul_y = p;
        @(posedge clk);
        #1 mul_valid = 1'b0;
        mul_y = ~p;
        model_busy = 1'b0;
      end else if (spur_req != sd) begin
        sd = sd + 1;
        @(posedge clk);
        #1 mul_valid = 1'b1;
        mul_y = 32'h12345678;
        @(posedge clk);
        #1 mul_valid = 1'b0;
        mul_y = 32'h0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    in_valid = 1'b0;
    in_x1 = '0;
    in_x2 = '0;
    in_tag = '0;
    out_ready = 1'b0;
    foreign_busy = 1'b0;
    mul_lat = 1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (mul_en !== 1'b0) begin n_fail++; $display("FAIL reset_mul_en: got %b want 0", mul_en); end
    n_checks++; if (mul_x1 !== 32'h0 || mul_x2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_mul_x: got %h/%h want 0/0", mul_x1, mul_x2); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_y !== 32'h0 || out_tag !== 5'd0) begin
      n_fail++; $display("FAIL reset_out_data: got %h/%0d want 0/0", out_y, out_tag); end
  endtask

  task automatic test_single();
    do_reset();
    in_x1 = 32'h40000000; in_x2 = 32'h40400000; in_tag = 5'd7; in_valid = 1'b1;
    @(negedge clk);  // after E0: accepted
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1 || mul_en !== 1'b0) begin
      n_fail++; $display("FAIL single_e0: count=%0d mul_en=%b want 1/0", count, mul_en); end
    @(negedge clk);  // after E1: launched
    n_checks++; if (mul_en !== 1'b1 || count !== 3'd0) begin
      n_fail++; $display("FAIL single_e1_en: mul_en=%b count=%0d want 1/0", mul_en, count); end
    n_checks++; if (mul_x1 !== 32'h40000000 || mul_x2 !== 32'h40400000) begin
      n_fail++; $display("FAIL single_operands: got %h/%h want 40000000/40400000", mul_x1, mul_x2); end
    @(negedge clk);  // after E2
    n_checks++; if (mul_en !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_e2: mul_en=%b out_valid=%b want 0/0", mul_en, out_valid); end
    @(negedge clk);  // after E3: result
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'h40C00000 || out_tag !== 5'd7) begin
      n_fail++; $display("FAIL single_result: v=%b y=%h tag=%0d want 1/40c00000/7", out_valid, out_y, out_tag); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_fill_backpressure();
    op_t ops[5];
    int  acc, en_cnt, got, bad;
    do_reset();
    foreign_busy = 1'b1;
    acc = 0; en_cnt = 0; bad = 0; got = 0;
    for (int i = 0; i < 5; i++) begin
      ops[i].x1 = rand_val(); ops[i].x2 = rand_val(); ops[i].tag = TAG_W'(10 + i);
      in_x1 = ops[i].x1; in_x2 = ops[i].x2; in_tag = ops[i].tag; in_valid = 1'b1;
      if (in_ready) acc++;
      @(negedge clk);
      if (mul_en) en_cnt++;
    end
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mul_en) en_cnt++;
    end
    n_checks++; if (acc != 4 || count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: accepted=%0d count=%0d in_ready=%b want 4/4/0", acc, count, in_ready); end
    n_checks++; if (en_cnt != 0) begin n_fail++; $display("FAIL fill_busy_hold: mul_en pulses=%0d want 0", en_cnt); end
    foreign_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (mul_en) en_cnt++;
    end
    n_checks++; if (en_cnt != 1 || count !== 3'd3 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_issue: pulses=%0d count=%0d in_ready=%b want 1/3/1", en_cnt, count, in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd10 || out_y !== fp_mul(ops[0].x1, ops[0].x2)) begin
      n_fail++; $display("FAIL fill_first_result: v=%b y=%h tag=%0d want 1/%h/10",
                         out_valid, out_y, out_tag, fp_mul(ops[0].x1, ops[0].x2)); end
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_tag !== 5'd10 || out_y !== fp_mul(ops[0].x1, ops[0].x2) || mul_en) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL backpressure_hold: unstable cycles=%0d want 0", bad); end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (out_valid) begin
        n_checks++; if (out_tag !== ops[got].tag || out_y !== fp_mul(ops[got].x1, ops[got].x2)) begin
          n_fail++; $display("FAIL drain_result%0d: y=%h tag=%0d want %h/%0d", got, out_y, out_tag,
                             fp_mul(ops[got].x1, ops[got].x2), ops[got].tag); end
        got++;
      end
      @(negedge clk);
    end
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL drain_count: got %0d results want 4", got); end
    out_ready = 1'b0;
  endtask

  task automatic test_ordering();
    op_t ops[4];
    int  en_t[8];
    int  n_en, n_res;
    do_reset();
    out_ready = 1'b1;
    n_en = 0; n_res = 0;
    for (int i = 0; i < 4; i++) begin
      ops[i].x1 = rand_val(); ops[i].x2 = rand_val(); ops[i].tag = TAG_W'(i + 1);
    end
    for (int c = 0; c < 60; c++) begin
      if (mul_en && n_en < 8) begin en_t[n_en] = c; n_en++; end
      if (out_valid) begin
        if (n_res < 4) begin
          n_checks++; if (out_tag !== ops[n_res].tag || out_y !== fp_mul(ops[n_res].x1, ops[n_res].x2)) begin
            n_fail++; $display("FAIL order_result%0d: y=%h tag=%0d want %h/%0d", n_res, out_y, out_tag,
                               fp_mul(ops[n_res].x1, ops[n_res].x2), ops[n_res].tag); end
        end
        n_res++;
      end
      if (c < 4) begin
        in_x1 = ops[c].x1; in_x2 = ops[c].x2; in_tag = ops[c].tag; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++; if (n_en != 4 || n_res != 4) begin
      n_fail++; $display("FAIL order_counts: mul_en=%0d results=%0d want 4/4", n_en, n_res); end
    for (int k = 0; k < 3 && k + 1 < n_en; k++) begin
      n_checks++; if (en_t[k+1] - en_t[k] != 4) begin
        n_fail++; $display("FAIL order_spacing%0d: got %0d cycles want 4", k, en_t[k+1] - en_t[k]); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_zero_sign();
    logic [31:0] a[2], b[2], e[2];
    int          w;
    a = '{32'h00000000, 32'hBF800000};
    b = '{32'hC0000000, 32'h40000000};
    e = '{32'h00000000, 32'hC0000000};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_x1 = a[i]; in_x2 = b[i]; in_tag = TAG_W'(20 + i); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 10) begin @(negedge clk); w++; end
      n_checks++; if (out_valid !== 1'b1 || out_y !== e[i] || out_tag !== TAG_W'(20 + i)) begin
        n_fail++; $display("FAIL zero_sign%0d: v=%b y=%h tag=%0d want 1/%h/%0d", i, out_valid, out_y, out_tag, e[i], 20 + i); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || out_y !== e[i]) begin
        n_fail++; $display("FAIL zero_sign_hold%0d: v=%b y=%h want 0/%h", i, out_valid, out_y, e[i]); end
    end
  endtask

  task automatic test_spurious();
    int bad, w;
    do_reset();
    bad = 0;
    spur_req++;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out_y !== 32'h0 || count !== 3'd0 || mul_en) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL spurious_valid: disturbed cycles=%0d want 0", bad); end
    in_x1 = 32'h3FC00000; in_x2 = 32'h40000000; in_tag = 5'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin @(negedge clk); w++; end
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'h40400000 || out_tag !== 5'd3) begin
      n_fail++; $display("FAIL spurious_after: v=%b y=%h tag=%0d want 1/40400000/3", out_valid, out_y, out_tag); end
  endtask

  task automatic test_reset_wait();
    int bad;
    do_reset();
    mul_lat = 4;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      in_x1 = rand_val(); in_x2 = rand_val(); in_tag = TAG_W'(i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (mul_en !== 1'b0 || count !== 3'd2) begin
      n_fail++; $display("FAIL rstwait_pre: mul_en=%b count=%0d want 0/2", mul_en, count); end
    reset = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstwait_async: count=%0d v=%b in_ready=%b want 0/0/1", count, out_valid, in_ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || mul_en !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstwait_late_valid: bad cycles=%0d want 0", bad); end
    mul_lat = 1;
  endtask

  task automatic test_random();
    op_t pend_q[$];
    op_t fly_q[$];
    op_t op;
    int  acc, iss, ret;
    bit  drain;
    do_reset();
    acc = 0; iss = 0; ret = 0;
    for (int c = 0; c < 1500; c++) begin
      drain = (c >= 600);
      if (mul_en) begin
        if (pend_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rand_issue_empty: mul_en with no queued op at cycle %0d", c);
        end else begin
          op = pend_q.pop_front();
          n_checks++; if (mul_x1 !== op.x1 || mul_x2 !== op.x2) begin
            n_fail++; $display("FAIL rand_operands: got %h/%h want %h/%h", mul_x1, mul_x2, op.x1, op.x2); end
          fly_q.push_back(op);
        end
        iss++;
      end
      n_checks++; if (int'(count) !== acc - iss) begin
        n_fail++; $display("FAIL rand_count: got %0d want %0d at cycle %0d", count, acc - iss, c); end
      n_checks++; if (in_ready !== ((acc - iss) != DEPTH)) begin
        n_fail++; $display("FAIL rand_in_ready: got %b with occupancy %0d", in_ready, acc - iss); end
      in_valid = !drain && ($urandom_range(0, 2) != 0);
      in_x1 = rand_val(); in_x2 = rand_val(); in_tag = TAG_W'($urandom);
      if (in_valid && in_ready) begin
        op.x1 = in_x1; op.x2 = in_x2; op.tag = in_tag;
        pend_q.push_back(op);
        acc++;
      end
      out_ready = drain || ($urandom_range(0, 1) == 1);
      foreign_busy = !drain && ($urandom_range(0, 7) == 0);
      mul_lat = $urandom_range(1, 3);
      if (out_valid && out_ready) begin
        if (fly_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rand_result_unexpected: y=%h tag=%0d", out_y, out_tag);
        end else begin
          op = fly_q.pop_front();
          n_checks++; if (out_y !== fp_mul(op.x1, op.x2) || out_tag !== op.tag) begin
            n_fail++; $display("FAIL rand_result: y=%h tag=%0d want %h/%0d", out_y, out_tag, fp_mul(op.x1, op.x2), op.tag); end
          ret++;
        end
      end
      if (drain && pend_q.size() == 0 && fly_q.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    n_checks++; if (ret != acc || acc == 0) begin
      n_fail++; $display("FAIL rand_drain: returned %0d of %0d accepted", ret, acc); end
    out_ready = 1'b0;
    foreign_busy = 1'b0;
    mul_lat = 1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    spur_req = 0;
    mul_lat = 1;
    foreign_busy = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_backpressure();
    test_ordering();
    test_zero_sign();
    test_spurious();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
